uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit FIFO write port between NUM_REQ message sources, e.g. the Morse decoder echo and a status reporter.
- Grants whole messages: once a source is granted, it keeps the FIFO until it presents a byte flagged last.
- Selection is round-robin. Backpressure comes from FIFO full.
- Sits between the message producers and the uart_top transmit FIFO.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- WORD_BITS, 8: byte width; matches the UART word.
- MAX_MSG_BYTES, 64: maximum beats per grant before forced release.
- CNT_BITS, $clog2(MAX_MSG_BYTES+1): width of the beat counter.

Ports:
- clk_i  in  1  system clock.
- reset_ni  in  1  asynchronous, active-low reset.
- req_i  in  NUM_REQ  per-source request; held high while the source has a message pending.
- valid_i  in  NUM_REQ  per-source byte valid.
- last_i  in  NUM_REQ  per-source last-byte-of-message flag; qualified by valid.
- data_i  in  NUM_REQ*WORD_BITS  per-source byte; source k occupies bits [k*WORD_BITS +: WORD_BITS].
- ready_o  out  NUM_REQ  per-source accept.
- grant_o  out  NUM_REQ  one-hot current owner; all zeros when idle.
- fifo_full_i  in  1  TX FIFO full.
- fifo_wr_o  out  1  TX FIFO write strobe.
- fifo_data_o  out  WORD_BITS  TX FIFO write data.
- busy_o  out  1  high in ACTIVE.
- abort_o  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset (asynchronous, reset_ni=0):
  - state=IDLE, grant_o=0, beat count=0, abort_o=0.
  - Round-robin pointer is set to last-owner=NUM_REQ-1, so source 0 has top priority for the first grant.
  - fifo_wr_o and ready_o are forced 0 immediately, including mid-message. A partial message already in the FIFO is not retracted.
- IDLE:
  - ready_o=0, fifo_wr_o=0.
  - If any req_i is high, the winner is the first set bit searching upward from last-owner+1 with wrap.
  - On the next edge: grant_o is loaded one-hot with the winner, count=0, state=ACTIVE.
  - No req_i: stay in IDLE.
- ACTIVE (owner g):
  - ready_o[g] = ~fifo_full_i; all other ready_o bits are 0.
  - A beat is accepted when valid_i[g] & ready_o[g].
  - fifo_wr_o equals beat acceptance (combinational, zero latency). fifo_data_o = data_i of g; it is don't-care when there is no write but is driven from g.
  - Each accepted beat increments count.
- Leaving ACTIVE:
  - Accepted beat with last_i[g]=1: next edge state=IDLE, grant_o=0, last-owner=g.
  - Accepted beat without last, with count==MAX_MSG_BYTES-1 (the MAX_MSG_BYTES-th byte): same release, plus abort_o=1 for exactly one cycle (registered).
- Inter-message gap: at least one IDLE cycle between messages. Peak throughput is one byte per cycle within a message.
- Requests during ACTIVE:
  - req_i of other sources is ignored.
  - req_i[g] dropping while ACTIVE does not release the grant; only last or abort releases it.
- fifo_full_i high with valid_i[g] high: no write, ready_o[g]=0, count unchanged. The source must hold data, valid and last stable.
- Simultaneous requests at the IDLE decision: round-robin order only. With all sources requesting continuously, grants rotate 0,1,...,NUM_REQ-1,0.
- No combinational path from req_i to any output. grant_o, busy_o and abort_o are registered. ready_o, fifo_wr_o and fifo_data_o are combinational on registered grant, valid_i, data_i and fifo_full_i.

Decomposition:
- Package uart_arb_pkg:
  - state encoding (ST_IDLE, ST_ACTIVE);
  - default NUM_REQ, WORD_BITS, MAX_MSG_BYTES.
- Sub-module rr_arbiter: combinational round-robin priority select.
  - Inputs: req vector, last-owner index.
  - Outputs: one-hot winner and any-request flag.
- The top module holds the FSM, pointer, beat counter and datapath mux.

Test Plan:
- Reset then single request:
  - Stimulus: req_i=01; source 0 sends 0x48,0x49 with last on 0x49; fifo_full_i=0.
  - Required: grant_o=01 one cycle after the request; two fifo_wr_o pulses carrying 0x48 then 0x49; grant_o=00 on the following cycle.
- Contention:
  - Stimulus: req_i=11 held; each source sends a 1-byte message (0xAA from source 0, 0x55 from source 1).
  - Required: grants alternate 01,10,01; FIFO sees 0xAA,0x55,0xAA.
- Backpressure:
  - Stimulus: fifo_full_i=1 for 5 cycles mid-message on byte 0x33.
  - Required: no fifo_wr_o and ready_o[g]=0 during the stall; 0x33 is written exactly once after full drops; count unchanged during the stall.
- Forced release:
  - Stimulus: MAX_MSG_BYTES=4; a source streams 6 bytes with no last.
  - Required: 4 writes, then a single abort_o pulse and grant_o=0; the other pending source is granted next.
- Reset mid-message:
  - Stimulus: reset_ni pulled low between clock edges while a message is in progress.
  - Required: fifo_wr_o, ready_o and grant_o go 0 immediately, without waiting for a clock edge; after release, the first grant goes to source 0 when req_i=11.
- UART end-to-end:
  - Stimulus: uart_top fed from the arbiter; source 1 sends 0xCC with last.
  - Required: tx line carries start 0, data LSB-first 0,0,1,1,0,0,1,1, stop 1.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit FIFO arbiter.
package uart_arb_pkg;

    localparam int unsigned DEF_NUM_REQ       = 2;
    localparam int unsigned DEF_WORD_BITS     = 8;
    localparam int unsigned DEF_MAX_MSG_BYTES = 64;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: first request above the last owner, with wrap.
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned IDX_BITS = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [IDX_BITS-1:0] last_owner,
    output logic [NUM_REQ-1:0]  winner,
    output logic                any_req
);

    logic                found;
    logic [IDX_BITS-1:0] pos;

    // Walk the request vector starting one past the last owner; first hit wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        pos    = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            pos = IDX_BITS'((32'(last_owner) + i) % NUM_REQ);
            if (!found && req[pos]) begin
                winner[pos] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing the UART TX FIFO write port.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ       = DEF_NUM_REQ,
    parameter int unsigned WORD_BITS     = DEF_WORD_BITS,
    parameter int unsigned MAX_MSG_BYTES = DEF_MAX_MSG_BYTES,
    parameter int unsigned CNT_BITS      = $clog2(MAX_MSG_BYTES + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_ni,
    input  logic [NUM_REQ-1:0]           req_i,
    input  logic [NUM_REQ-1:0]           valid_i,
    input  logic [NUM_REQ-1:0]           last_i,
    input  logic [NUM_REQ*WORD_BITS-1:0] data_i,
    output logic [NUM_REQ-1:0]           ready_o,
    output logic [NUM_REQ-1:0]           grant_o,
    input  logic                         fifo_full_i,
    output logic                         fifo_wr_o,
    output logic [WORD_BITS-1:0]         fifo_data_o,
    output logic                         busy_o,
    output logic                         abort_o
);

    localparam int unsigned         IDX_BITS  = $clog2(NUM_REQ);
    localparam logic [IDX_BITS-1:0] LAST_IDX  = IDX_BITS'(NUM_REQ - 1);
    localparam logic [CNT_BITS-1:0] CNT_LIMIT = CNT_BITS'(MAX_MSG_BYTES - 1);

    arb_state_e           state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDX_BITS-1:0]  owner_q, owner_d;   // current owner in ACTIVE, last owner in IDLE
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic                 abort_q, abort_d;

    logic [NUM_REQ-1:0]   win_oh;
    logic                 any_req;
    logic [IDX_BITS-1:0]  win_idx;
    logic                 accept;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req        (req_i),
        .last_owner (owner_q),
        .winner     (win_oh),
        .any_req    (any_req)
    );

    // One-hot winner to index for the owner pointer.
    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                win_idx = IDX_BITS'(i);
            end
        end
    end

    // State register with the registered grant, pointer, beat count and abort pulse.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            owner_q <= LAST_IDX;
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
        end
    end

    // Next-state: grant on any request in IDLE, release on last or on beat limit.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        abort_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_ACTIVE;
                    grant_d = win_oh;
                    owner_d = win_idx;
                    cnt_d   = '0;
                end
            end
            ST_ACTIVE: begin
                if (accept) begin
                    if (last_i[owner_q]) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LIMIT) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        cnt_d   = '0;
                        abort_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_BITS'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Outputs: owner's ready and FIFO write follow full and valid with zero latency.
    always_comb begin
        ready_o     = '0;
        accept      = 1'b0;
        fifo_data_o = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_BITS'(i)) begin
                fifo_data_o = data_i[i*WORD_BITS +: WORD_BITS];
            end
        end
        if (state_q == ST_ACTIVE) begin
            ready_o[owner_q] = ~fifo_full_i;
            accept           = valid_i[owner_q] & ~fifo_full_i;
        end
        fifo_wr_o = accept;
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q == ST_ACTIVE);
    assign abort_o = abort_q;

endmodule
